world_map_arbiter: RTL and testbench
====================================

# world_map_arbiter

Shares the single-read-port world-map memory between two requesters: the display fetch path, which supplies `world_pixel` to the colorizer, and the RojoBot sensor/location lookup. Display requests have strict priority and a fixed latency so video timing is never disturbed. Bot lookups use a req/ack handshake and are served in idle memory slots. A starvation monitor flags a bot request that waits too long.

## Interface
- `ADDR_W`, default 14: map address width (128x128 map).
- `PIX_W`, default 2: map pixel code width.
- `STARVE_LIMIT`, default 1024: wait cycles before `bot_starve` sets; must be ≥ 2.
- `clk` in 1: system clock; all logic on its rising edge.
- `reset` in 1: asynchronous, active-high reset.
- `disp_req` in 1: display fetch request; may assert every cycle.
- `disp_addr` in ADDR_W: display fetch address, sampled with `disp_req`.
- `disp_valid` out 1: one-cycle pulse; `disp_pixel` is valid.
- `disp_pixel` out PIX_W: fetched display pixel code.
- `bot_req` in 1: bot lookup request; level, held until ack.
- `bot_addr` in ADDR_W: bot lookup address; must be stable while `bot_req` is high.
- `bot_ack` out 1: one-cycle pulse; `bot_data` is valid.
- `bot_data` out PIX_W: fetched bot pixel code.
- `bot_starve` out 1: sticky starvation flag; cleared only by `reset`.
- `mem_addr` out ADDR_W: registered address to the map memory.
- `mem_data` in PIX_W: map memory data, valid one cycle after `mem_addr` (synchronous read).

## Operation
- **Issue, per cycle, evaluated at the rising edge:**
  - `disp_req`=1: issue the display read; `mem_addr` <= `disp_addr`; tag = DISP.
  - Otherwise, if `bot_req`=1 and FSM is IDLE: issue the bot read; `mem_addr` <= `bot_addr`; tag = BOT; FSM -> PEND.
  - Otherwise: no issue; `mem_addr` holds its value; tag invalid.
- **Tag pipeline:** two stages of {valid, owner}, aligned with the memory latency. The stage-2 entry selects the destination of `mem_data`.
- **Bot FSM:**
  - IDLE -> PEND on issue.
  - PEND -> ACK when the BOT tag reaches stage 2 and the data is registered.
  - ACK -> IDLE unconditionally after one cycle.
  - Requester must drop `bot_req` in the ACK cycle. A `bot_req` still high in the cycle after ACK is treated as a new request.
- **Outstanding bot reads:** at most one.
- **Display reads:** unlimited back-to-back; never stalled or dropped.
- **Starvation counter:**
  - Increments each cycle `bot_req`=1 and FSM=IDLE and no bot issue occurs.
  - Clears on bot issue.
  - Saturates at STARVE_LIMIT.
  - Reaching STARVE_LIMIT sets `bot_starve` (sticky).
- **Pixel codes pass through unmodified:** 00 background, 01 black line, 10 obstruction, 11 reserved.

## Timing
- **Reset values:** `disp_valid`=0, `disp_pixel`=0, `bot_ack`=0, `bot_data`=0, `bot_starve`=0, `mem_addr`=0, FSM=IDLE, tags invalid, counter=0.
- **Display latency:** `disp_req` sampled at the edge ending cycle n gives `mem_addr` in cycle n+1, `mem_data` in cycle n+2, and `disp_valid`/`disp_pixel` registered in cycle n+3. Latency is exactly 3 cycles, one result per request, in request order.
- **Bot latency:** issue at the edge ending cycle n gives `bot_ack` in cycle n+3. A minimum of 3 cycles when the display is idle; unbounded under continuous `disp_req`.
- `disp_pixel`/`bot_data` hold their last value when the corresponding valid/ack is low.
- **Simultaneous requests:** display wins; the bot request stays pending with no loss.
- **Reset mid-operation:** in-flight tags are discarded, no valid/ack is emitted afterwards, and a pending bot request is re-arbitrated after reset deasserts.
- The counter never wraps.

## Structure
- **Shared package:**
  - Tag owner encoding (DISP/BOT).
  - FSM state encoding (IDLE, PEND, ACK).
  - Pixel code constants: BG=2'b00, LINE=2'b01, OBST=2'b10, RSVD=2'b11.
- **Sub-module `map_rd_tag_pipe`:** the 2-stage {valid, owner} shift register with asynchronous reset. Instantiated once.
- The issue mux, FSM, starvation counter and output registers live in `world_map_arbiter`.

## Test plan
- **Display only:** `disp_req`=1 for 8 cycles, addresses 0..7, memory model returns addr[1:0] → `disp_valid` high cycles n+3..n+10 with pixels 0,1,2,3,0,1,2,3.
- **Bot only:** `bot_req`=1, `bot_addr`=0x1234, memory returns 2'b10 → `bot_ack` one pulse exactly 3 cycles after issue, `bot_data`=2'b10; FSM returns to IDLE.
- **Collision:** `disp_req` and `bot_req` rise in the same cycle; display drops after 1 cycle → display result at +3, bot result at +4; `mem_addr` sequence is disp_addr then bot_addr.
- **Starvation:** STARVE_LIMIT=16, `disp_req` held high 20 cycles with `bot_req` high → `bot_starve` rises after 16 waiting cycles and stays high after the bot is acked; no display result lost.
- **Reset mid-flight:** assert `reset` one cycle after a bot issue → `bot_ack` never pulses; all outputs 0 during reset; after release with `bot_req` still high, the bot is re-served with ack 3 cycles after issue.
- **Back-to-back bot:** `bot_req` held high through ACK → second issue occurs no earlier than the cycle after ACK; exactly two acks observed.

Source files
------------

// File: rtl/world_map_arbiter_pkg.sv
// Shared types and constants for the world-map read arbiter: tag owners,
// bot handshake states and the map pixel codes.
package world_map_arbiter_pkg;

    typedef enum logic {
        OWN_DISP = 1'b0,
        OWN_BOT  = 1'b1
    } owner_e;

    typedef struct packed {
        logic   valid;
        owner_e owner;
    } tag_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_PEND = 2'd1,
        ST_ACK  = 2'd2
    } bot_state_e;

    localparam logic [1:0] PIX_BG   = 2'b00;
    localparam logic [1:0] PIX_LINE = 2'b01;
    localparam logic [1:0] PIX_OBST = 2'b10;
    localparam logic [1:0] PIX_RSVD = 2'b11;

endpackage

// File: rtl/world_map_arbiter_tag_pipe.sv
// Two-stage {valid, owner} shift register that tracks which requester owns
// each read in flight through the synchronous map memory.
module map_rd_tag_pipe
    import world_map_arbiter_pkg::*;
(
    input  logic clk,
    input  logic reset,
    input  tag_t tag_in,
    output tag_t stage1,
    output tag_t stage2
);

    tag_t stage1_d, stage1_q;
    tag_t stage2_d, stage2_q;

    always_comb begin
        stage1_d = tag_in;
        stage2_d = stage1_q;
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge value of its neighbour; blocking here would collapse the
    // two stages into one.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stage1_q <= '0;
            stage2_q <= '0;
        end else begin
            stage1_q <= stage1_d;
            stage2_q <= stage2_d;
        end
    end

    assign stage1 = stage1_q;
    assign stage2 = stage2_q;

endmodule

// File: rtl/world_map_arbiter.sv
// Shares the single-port world-map memory between the display fetch path
// (strict priority, fixed 3-cycle latency) and the bot req/ack lookup.
module world_map_arbiter
    import world_map_arbiter_pkg::*;
#(
    parameter int ADDR_W       = 14,
    parameter int PIX_W        = 2,
    parameter int STARVE_LIMIT = 1024
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              disp_req,
    input  logic [ADDR_W-1:0] disp_addr,
    output logic              disp_valid,
    output logic [PIX_W-1:0]  disp_pixel,
    input  logic              bot_req,
    input  logic [ADDR_W-1:0] bot_addr,
    output logic              bot_ack,
    output logic [PIX_W-1:0]  bot_data,
    output logic              bot_starve,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [PIX_W-1:0]  mem_data
);

    localparam int                CNT_W = $clog2(STARVE_LIMIT + 1);
    localparam logic [CNT_W-1:0]  LIMIT = CNT_W'(STARVE_LIMIT);

    bot_state_e        state_d, state_q;
    logic [ADDR_W-1:0] mem_addr_d, mem_addr_q;
    logic              disp_valid_d, disp_valid_q;
    logic [PIX_W-1:0]  disp_pixel_d, disp_pixel_q;
    logic              bot_ack_d, bot_ack_q;
    logic [PIX_W-1:0]  bot_data_d, bot_data_q;
    logic [CNT_W-1:0]  cnt_d, cnt_q;
    logic              starve_d, starve_q;

    logic bot_issue;
    tag_t tag_in, tag_s1, tag_s2;

    map_rd_tag_pipe u_tag_pipe (
        .clk    (clk),
        .reset  (reset),
        .tag_in (tag_in),
        .stage1 (tag_s1),
        .stage2 (tag_s2)
    );

    // NOTE: every signal written here gets a default first, so no path through
    // the block can leave one unassigned and infer a latch.
    always_comb begin
        bot_issue  = !disp_req && bot_req && (state_q == ST_IDLE);
        mem_addr_d = mem_addr_q;
        tag_in     = '0;
        state_d    = state_q;
        cnt_d      = cnt_q;

        if (disp_req) begin
            mem_addr_d = disp_addr;
            tag_in     = '{valid: 1'b1, owner: OWN_DISP};
        end else if (bot_issue) begin
            mem_addr_d = bot_addr;
            tag_in     = '{valid: 1'b1, owner: OWN_BOT};
        end

        case (state_q)
            ST_IDLE: if (bot_issue) state_d = ST_PEND;
            ST_PEND: if (tag_s2.valid && tag_s2.owner == OWN_BOT) state_d = ST_ACK;
            ST_ACK:  state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase

        // Stage 2 lines up with mem_data, so it alone steers the result.
        disp_valid_d = tag_s2.valid && (tag_s2.owner == OWN_DISP);
        disp_pixel_d = disp_valid_d ? mem_data : disp_pixel_q;
        bot_ack_d    = tag_s2.valid && (tag_s2.owner == OWN_BOT);
        bot_data_d   = bot_ack_d ? mem_data : bot_data_q;

        if (bot_issue) begin
            cnt_d = '0;
        end else if (bot_req && (state_q == ST_IDLE) && (cnt_q != LIMIT)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
        starve_d = starve_q || (cnt_d == LIMIT);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            mem_addr_q   <= '0;
            disp_valid_q <= 1'b0;
            disp_pixel_q <= '0;
            bot_ack_q    <= 1'b0;
            bot_data_q   <= '0;
            cnt_q        <= '0;
            starve_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            mem_addr_q   <= mem_addr_d;
            disp_valid_q <= disp_valid_d;
            disp_pixel_q <= disp_pixel_d;
            bot_ack_q    <= bot_ack_d;
            bot_data_q   <= bot_data_d;
            cnt_q        <= cnt_d;
            starve_q     <= starve_d;
        end
    end

    assign mem_addr   = mem_addr_q;
    assign disp_valid = disp_valid_q;
    assign disp_pixel = disp_pixel_q;
    assign bot_ack    = bot_ack_q;
    assign bot_data   = bot_data_q;
    assign bot_starve = starve_q;

endmodule

// File: tb/tb_world_map_arbiter.sv
// Scoreboard bench for world_map_arbiter: directed stimulus pushes expected
// {data, edge} entries; a negedge monitor pops them as results appear.
module tb_world_map_arbiter;
    import world_map_arbiter_pkg::*;

    localparam int AW = 14;
    localparam int PW = 2;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          disp_req = 1'b0;
    logic [AW-1:0] disp_addr = '0;
    logic          disp_valid;
    logic [PW-1:0] disp_pixel;
    logic          bot_req = 1'b0;
    logic [AW-1:0] bot_addr = '0;
    logic          bot_ack;
    logic [PW-1:0] bot_data;
    logic          bot_starve;
    logic [AW-1:0] mem_addr;
    logic [PW-1:0] mem_data = '0;

    world_map_arbiter #(
        .ADDR_W       (AW),
        .PIX_W        (PW),
        .STARVE_LIMIT (16)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .disp_req   (disp_req),
        .disp_addr  (disp_addr),
        .disp_valid (disp_valid),
        .disp_pixel (disp_pixel),
        .bot_req    (bot_req),
        .bot_addr   (bot_addr),
        .bot_ack    (bot_ack),
        .bot_data   (bot_data),
        .bot_starve (bot_starve),
        .mem_addr   (mem_addr),
        .mem_data   (mem_data)
    );

    always #5 clk = ~clk;

    int edges = 0;
    always @(posedge clk) edges <= edges + 1;

    function automatic logic [PW-1:0] mem_fn(input logic [AW-1:0] a);
        if (a == 14'h1234) return PIX_OBST;
        return a[1:0];
    endfunction

    always @(posedge clk) mem_data <= mem_fn(mem_addr);

    typedef struct {
        logic [PW-1:0] data;
        int            at;
    } exp_t;

    exp_t disp_q[$];
    exp_t bot_q[$];
    exp_t me;
    int   n_tests = 0;
    int   n_fail  = 0;
    int   n_acks  = 0;
    int   n_disp  = 0;
    int   k;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (edge %0d)", name, act, exp, edges);
        end
    endtask

    always @(negedge clk) begin
        if (disp_valid) begin
            n_disp++;
            if (disp_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL disp_unexpected: got disp_valid with pixel %0h, expected none (edge %0d)",
                         disp_pixel, edges);
            end else begin
                me = disp_q.pop_front();
                check("disp_pixel", 32'(disp_pixel), 32'(me.data));
                check("disp_latency", edges, me.at);
            end
        end
        if (bot_ack) begin
            n_acks++;
            if (bot_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL bot_unexpected: got bot_ack with data %0h, expected none (edge %0d)",
                         bot_data, edges);
            end else begin
                me = bot_q.pop_front();
                check("bot_data", 32'(bot_data), 32'(me.data));
                check("bot_latency", edges, me.at);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ack();
        for (int i = 0; i < 64; i++) begin
            if (bot_ack) break;
            tick();
        end
        check("bot_ack_seen", 32'(bot_ack), 32'd1);
        bot_req = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_disp_valid"}, 32'(disp_valid), 32'd0);
        check({tag, "_disp_pixel"}, 32'(disp_pixel), 32'd0);
        check({tag, "_bot_ack"},    32'(bot_ack),    32'd0);
        check({tag, "_bot_data"},   32'(bot_data),   32'd0);
        check({tag, "_bot_starve"}, 32'(bot_starve), 32'd0);
        check({tag, "_mem_addr"},   32'(mem_addr),   32'd0);
    endtask

    initial begin
        #50000;
        $display("FAIL watchdog: simulation still running at %0t", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin
        #1 reset = 1'b1;
        tick();
        tick();
        check_reset_outputs("reset");
        reset = 1'b0;
        tick();
        tick();

        // Display only: addresses 0..7, pixels follow addr[1:0].
        for (int i = 0; i < 8; i++) begin
            disp_req  = 1'b1;
            disp_addr = AW'(i);
            disp_q.push_back('{data: PW'(i), at: edges + 3});
            tick();
        end
        disp_req = 1'b0;
        repeat (6) tick();
        check("mem_addr_hold", 32'(mem_addr), 32'd7);
        check("disp_pixel_hold", 32'(disp_pixel), 32'd3);

        // Bot only.
        bot_req  = 1'b1;
        bot_addr = 14'h1234;
        bot_q.push_back('{data: PIX_OBST, at: edges + 3});
        wait_ack();
        repeat (4) tick();
        check("bot_data_hold", 32'(bot_data), 32'(PIX_OBST));

        // Collision: display first, bot one cycle later.
        k         = edges;
        disp_req  = 1'b1;
        disp_addr = 14'h0005;
        bot_req   = 1'b1;
        bot_addr  = 14'h1234;
        disp_q.push_back('{data: PIX_LINE, at: k + 3});
        bot_q.push_back('{data: PIX_OBST, at: k + 4});
        tick();
        check("collision_mem_addr_disp", 32'(mem_addr), 32'h0005);
        disp_req = 1'b0;
        tick();
        check("collision_mem_addr_bot", 32'(mem_addr), 32'h1234);
        wait_ack();
        repeat (4) tick();

        // Starvation: limit 16, display hogs the port for 20 cycles.
        check("starve_before", 32'(bot_starve), 32'd0);
        k        = edges;
        bot_req  = 1'b1;
        bot_addr = 14'h0022;
        for (int i = 0; i < 20; i++) begin
            disp_req  = 1'b1;
            disp_addr = AW'(14'h0100 + i);
            disp_q.push_back('{data: PW'(i), at: edges + 3});
            tick();
            check($sformatf("starve_cycle_%0d", i), 32'(bot_starve), (i >= 15) ? 32'd1 : 32'd0);
        end
        disp_req = 1'b0;
        bot_q.push_back('{data: PIX_OBST, at: edges + 3});
        wait_ack();
        tick();
        check("starve_sticky", 32'(bot_starve), 32'd1);
        repeat (4) tick();

        // Reset one cycle after a bot issue; the bot is re-served afterwards.
        bot_req  = 1'b1;
        bot_addr = 14'h0033;
        tick();
        reset = 1'b1;
        #1;
        check_reset_outputs("midreset");
        tick();
        tick();
        check_reset_outputs("midreset_hold");
        reset = 1'b0;
        bot_q.push_back('{data: PIX_RSVD, at: edges + 3});
        wait_ack();
        repeat (4) tick();

        // Back-to-back bot: request held through ACK gives a second issue later.
        k        = edges;
        bot_req  = 1'b1;
        bot_addr = 14'h0011;
        bot_q.push_back('{data: PIX_LINE, at: k + 3});
        bot_q.push_back('{data: PIX_LINE, at: k + 7});
        while (edges < k + 7) tick();
        bot_req = 1'b0;
        repeat (8) tick();

        check("disp_queue_empty", disp_q.size(), 32'd0);
        check("bot_queue_empty", bot_q.size(), 32'd0);
        check("disp_result_count", n_disp, 32'd29);
        check("bot_ack_count", n_acks, 32'd6);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
